// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types, funct3 codes and access classification for mem_access_unit
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_SIZE     = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } fault_e;

    // Size legality is decided before alignment, so an illegal size never reports misalign.
    function automatic fault_e classify(input logic rd, input logic wr,
                                        input logic [2:0] f3, input logic [1:0] off);
        logic size_ok;
        size_ok = 1'b0;
        if (rd && !wr)
            size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                      (f3 == F3_BU) || (f3 == F3_HU);
        else if (wr && !rd)
            size_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!size_ok)
            return FLT_SIZE;
        if ((f3[1:0] == 2'b01) && off[0])
            return FLT_MISALIGN;
        if ((f3[1:0] == 2'b10) && (off != 2'b00))
            return FLT_MISALIGN;
        return FLT_NONE;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store byte-lane steering and load extraction/extension
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_st_data;
        case (i_st_size)
            2'b00: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
    assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - variable-latency MEM stage: request/grant/response bus master with stall and watchdog
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_mem_valid,
    input  logic [ADDR_WIDTH-1:0] ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_mem_rs2_data,
    input  logic                  ex_mem_MemRead,
    input  logic                  ex_mem_MemWrite,
    input  logic [2:0]            ex_mem_funct3,
    output logic                  mem_stall,
    output logic                  mem_out_valid,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [ADDR_WIDTH-1:0] mem_alu_result,
    output logic [1:0]            mem_fault,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_WIDTH-1:0] dbus_addr,
    output logic [DATA_WIDTH-1:0] dbus_wdata,
    output logic [3:0]            dbus_be,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [DATA_WIDTH-1:0] dbus_rdata
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("mem_access_unit: DATA_WIDTH must be 32");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_access_unit: TIMEOUT must be at least 2");
    end

    state_e                r_state;
    state_e                w_next;
    logic [ADDR_WIDTH-1:2] r_addr;
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [TO_W-1:0]       r_wdog;

    logic                  w_is_mem;
    fault_e                w_chk;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_timeout;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_ld_data;

    assign w_off    = ex_mem_alu_result[1:0];
    assign w_is_mem = ex_mem_MemRead | ex_mem_MemWrite;
    assign w_chk    = classify(ex_mem_MemRead, ex_mem_MemWrite, ex_mem_funct3, w_off);
    assign w_start  = (r_state == IDLE) && ex_mem_valid && w_is_mem && (w_chk == FLT_NONE);
    assign w_busy   = (r_state == REQ) || (r_state == WAIT);
    // r_wdog holds the cycles already spent busy, so this is the TIMEOUT-th busy cycle.
    assign w_timeout = w_busy && (r_wdog == TO_W'(TIMEOUT - 1));

    mem_lane_align u_lane_align (
        .i_st_size   (ex_mem_funct3[1:0]),
        .i_st_off    (w_off),
        .i_st_data   (ex_mem_rs2_data),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_ld_funct3 (r_funct3),
        .i_ld_off    (r_off),
        .i_rdata     (dbus_rdata),
        .o_ld_data   (w_ld_data)
    );

    assign dbus_req       = (r_state == REQ) && !w_timeout;
    assign dbus_we        = r_we;
    assign dbus_addr      = {r_addr, 2'b00};
    assign dbus_wdata     = r_wdata;
    assign dbus_be        = r_be;
    assign mem_alu_result = ex_mem_alu_result;

    always_comb begin
        w_next        = r_state;
        mem_stall     = 1'b0;
        mem_out_valid = 1'b0;
        mem_read_data = '0;
        mem_fault     = FLT_NONE;
        case (r_state)
            IDLE: begin
                if (ex_mem_valid) begin
                    if (!w_is_mem) begin
                        mem_out_valid = 1'b1;
                    end else if (w_chk != FLT_NONE) begin
                        mem_out_valid = 1'b1;
                        mem_fault     = w_chk;
                    end else begin
                        mem_stall = 1'b1;
                        w_next    = REQ;
                    end
                end
            end
            REQ: begin
                if (w_timeout) begin
                    w_next        = IDLE;
                    mem_out_valid = 1'b1;
                    mem_fault     = FLT_TIMEOUT;
                end else begin
                    mem_stall = 1'b1;
                    if (dbus_gnt)
                        w_next = WAIT;
                end
            end
            WAIT: begin
                // A response arriving on the last allowed cycle still wins over the abort.
                if (dbus_rvalid) begin
                    w_next        = IDLE;
                    mem_out_valid = 1'b1;
                    mem_read_data = w_ld_data;
                end else if (w_timeout) begin
                    w_next        = IDLE;
                    mem_out_valid = 1'b1;
                    mem_fault     = FLT_TIMEOUT;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_wdog   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_addr   <= ex_mem_alu_result[ADDR_WIDTH-1:2];
                r_we     <= ex_mem_MemWrite;
                r_wdata  <= ex_mem_MemWrite ? w_wdata : 32'h0;
                r_be     <= ex_mem_MemWrite ? w_be : 4'b1111;
                r_funct3 <= ex_mem_funct3;
                r_off    <= w_off;
                r_wdog   <= '0;
            end else if (w_busy) begin
                r_wdog <= r_wdog + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table-driven bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rs2_data;
    logic        ex_mem_MemRead;
    logic        ex_mem_MemWrite;
    logic [2:0]  ex_mem_funct3;
    logic        mem_stall;
    logic        mem_out_valid;
    logic [31:0] mem_read_data;
    logic [31:0] mem_alu_result;
    logic [1:0]  mem_fault;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_rs2_data   (ex_mem_rs2_data),
        .ex_mem_MemRead    (ex_mem_MemRead),
        .ex_mem_MemWrite   (ex_mem_MemWrite),
        .ex_mem_funct3     (ex_mem_funct3),
        .mem_stall         (mem_stall),
        .mem_out_valid     (mem_out_valid),
        .mem_read_data     (mem_read_data),
        .mem_alu_result    (mem_alu_result),
        .mem_fault         (mem_fault),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_wdata        (dbus_wdata),
        .dbus_be           (dbus_be),
        .dbus_gnt          (dbus_gnt),
        .dbus_rvalid       (dbus_rvalid),
        .dbus_rdata        (dbus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        single;
        logic [1:0]  fault;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_mem_valid    = 1'b0;
        ex_mem_MemRead  = 1'b0;
        ex_mem_MemWrite = 1'b0;
        dbus_gnt        = 1'b0;
        dbus_rvalid     = 1'b0;
    endtask

    task automatic present(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
        ex_mem_valid      = 1'b1;
        ex_mem_MemRead    = rd;
        ex_mem_MemWrite   = wr;
        ex_mem_funct3     = f3;
        ex_mem_alu_result = addr;
        ex_mem_rs2_data   = rs2;
    endtask

    task automatic run_vec(input vec_t v);
        present(v.rd, v.wr, v.f3, v.addr, v.rs2);
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        @(negedge clk);
        chk("alu_passthrough", mem_alu_result, v.addr);
        if (v.single) begin
            chk("single_out_valid", mem_out_valid, 1'b1);
            chk("single_fault", mem_fault, v.fault);
            chk("single_stall", mem_stall, 1'b0);
            chk("single_req", dbus_req, 1'b0);
            if (v.fault != 2'b00)
                chk("fault_data", mem_read_data, 32'h0);
        end else begin
            chk("detect_stall", mem_stall, 1'b1);
            chk("detect_out_valid", mem_out_valid, 1'b0);
            chk("detect_req", dbus_req, 1'b0);
            step();
            dbus_gnt = 1'b1;
            @(negedge clk);
            chk("req_req", dbus_req, 1'b1);
            chk("req_stall", mem_stall, 1'b1);
            chk("req_we", dbus_we, v.wr);
            chk("req_addr", dbus_addr, {v.addr[31:2], 2'b00});
            chk("req_be", dbus_be, v.be);
            chk("req_wdata", dbus_wdata, v.wdata);
            step();
            dbus_gnt    = 1'b0;
            dbus_rvalid = 1'b1;
            dbus_rdata  = v.rdata;
            @(negedge clk);
            chk("resp_stall", mem_stall, 1'b0);
            chk("resp_out_valid", mem_out_valid, 1'b1);
            chk("resp_fault", mem_fault, 2'b00);
            chk("resp_req", dbus_req, 1'b0);
            if (v.rd)
                chk("resp_data", mem_read_data, v.data);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        // rd wr f3 addr rs2 rdata single fault be wdata data
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1'b0, 2'b00, 4'b1000, 32'hA5A5_A5A5, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_8056, 1'b0, 2'b00, 4'b1111, 32'h0, 32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_8056, 1'b0, 2'b00, 4'b1111, 32'h0, 32'h0000_0080};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h1234_8056, 1'b0, 2'b00, 4'b1111, 32'h0, 32'h0000_1234};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 32'h1234_8056, 1'b0, 2'b00, 4'b1111, 32'h0, 32'hFFFF_8056};
        vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b00, 4'b1111, 32'h0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, 32'h0000_4002, 32'h1234_ABCD, 32'h0, 1'b0, 2'b00, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b00, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h7F00_0000, 1'b0, 2'b00, 4'b1111, 32'h0, 32'h0000_007F};
        vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'h0, 1'b1, 2'b01, 4'b0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 2'b10, 4'b0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 1'b1, 2'b01, 4'b0, 32'h0, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 1'b1, 2'b10, 4'b0, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 1'b1, 2'b10, 4'b0, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 3'b110, 32'h0000_4001, 32'h0, 32'h0, 1'b1, 2'b10, 4'b0, 32'h0, 32'h0};
        vecs[15] = '{1'b0, 1'b0, 3'b010, 32'hABCD_0123, 32'h0, 32'h0, 1'b1, 2'b00, 4'b0, 32'h0, 32'h0};
        vecs[16] = '{1'b0, 1'b1, 3'b000, 32'h0000_1000, 32'h0000_01FF, 32'h0, 1'b0, 2'b00, 4'b0001, 32'hFFFF_FFFF, 32'h0};

        rst_n             = 1'b0;
        ex_mem_alu_result = 32'h0000_0055;
        ex_mem_rs2_data   = 32'h0;
        ex_mem_funct3     = 3'b000;
        dbus_rdata        = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_out_valid", mem_out_valid, 1'b0);
        chk("rst_fault", mem_fault, 2'b00);
        chk("rst_data", mem_read_data, 32'h0);
        chk("rst_req", dbus_req, 1'b0);
        chk("rst_we", dbus_we, 1'b0);
        chk("rst_be", dbus_be, 4'b0);
        chk("rst_addr", dbus_addr, 32'h0);
        chk("rst_wdata", dbus_wdata, 32'h0);
        chk("rst_alu", mem_alu_result, 32'h0000_0055);
        step();
        rst_n = 1'b1;
        step();

        ex_mem_MemRead = 1'b1;
        @(negedge clk);
        chk("novalid_stall", mem_stall, 1'b0);
        chk("novalid_out_valid", mem_out_valid, 1'b0);
        step();
        idle_inputs();

        for (int i = 0; i < 17; i++)
            run_vec(vecs[i]);

        // Grant withheld for five cycles, response three cycles after grant.
        present(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0);
        @(negedge clk);
        chk("slow_detect_stall", mem_stall, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            dbus_rvalid = (k == 2);
            @(negedge clk);
            chk("slow_req_req", dbus_req, 1'b1);
            chk("slow_req_addr", dbus_addr, 32'h0000_6004);
            chk("slow_req_be", dbus_be, 4'b1111);
            chk("slow_req_stall", mem_stall, 1'b1);
            chk("slow_req_out_valid", mem_out_valid, 1'b0);
        end
        step();
        dbus_rvalid = 1'b0;
        dbus_gnt    = 1'b1;
        @(negedge clk);
        chk("slow_gnt_req", dbus_req, 1'b1);
        chk("slow_gnt_stall", mem_stall, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            dbus_gnt = 1'b0;
            @(negedge clk);
            chk("slow_wait_stall", mem_stall, 1'b1);
            chk("slow_wait_req", dbus_req, 1'b0);
            chk("slow_wait_out_valid", mem_out_valid, 1'b0);
        end
        step();
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0BAD_F00D;
        @(negedge clk);
        chk("slow_resp_stall", mem_stall, 1'b0);
        chk("slow_resp_out_valid", mem_out_valid, 1'b1);
        chk("slow_resp_data", mem_read_data, 32'h0BAD_F00D);
        step();
        idle_inputs();

        // No grant ever: the sixteenth busy cycle aborts.
        present(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        @(negedge clk);
        chk("to_detect_stall", mem_stall, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step();
            @(negedge clk);
            chk("to_busy_req", dbus_req, 1'b1);
            chk("to_busy_stall", mem_stall, 1'b1);
            chk("to_busy_out_valid", mem_out_valid, 1'b0);
        end
        step();
        @(negedge clk);
        chk("to_fault", mem_fault, 2'b11);
        chk("to_out_valid", mem_out_valid, 1'b1);
        chk("to_data", mem_read_data, 32'h0);
        chk("to_stall", mem_stall, 1'b0);
        chk("to_req", dbus_req, 1'b0);
        step();
        idle_inputs();
        dbus_rvalid = 1'b1;
        dbus_gnt    = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stray_out_valid", mem_out_valid, 1'b0);
            chk("stray_stall", mem_stall, 1'b0);
            chk("stray_req", dbus_req, 1'b0);
            chk("stray_fault", mem_fault, 2'b00);
            step();
        end
        idle_inputs();

        // Reset while waiting for a response.
        present(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0);
        step();
        dbus_gnt = 1'b1;
        step();
        dbus_gnt = 1'b0;
        @(negedge clk);
        chk("wait_pre_rst_stall", mem_stall, 1'b1);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("wait_rst_stall", mem_stall, 1'b0);
        chk("wait_rst_req", dbus_req, 1'b0);
        chk("wait_rst_out_valid", mem_out_valid, 1'b0);
        chk("wait_rst_fault", mem_fault, 2'b00);
        chk("wait_rst_addr", dbus_addr, 32'h0);
        chk("wait_rst_be", dbus_be, 4'b0);
        step();
        rst_n = 1'b1;
        run_vec(vecs[1]);

        // Reset while requesting drops dbus_req without waiting for a clock.
        present(1'b1, 1'b0, 3'b010, 32'h0000_9000, 32'h0);
        step();
        @(negedge clk);
        chk("req_pre_rst_req", dbus_req, 1'b1);
        #1;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("req_rst_req", dbus_req, 1'b0);
        chk("req_rst_stall", mem_stall, 1'b0);
        step();
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
